data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_WORD_BITS, default 8, SHALL set the word-index width; the array holds 2^ADDR_WORD_BITS 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal 1..7, SHALL set the cycles from request accept to response.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  MEM-stage access request, held stable by EX/MEM while stall=1.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I load/store funct3.
REQ-008 req_addr  input  REG_DATA_WIDTH (32)  byte address (ALU result).
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 stall  output  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM; bubbles MEM/WB.
REQ-011 resp_valid  output  1  one-cycle completion pulse; MEM/WB captures on this cycle.
REQ-012 resp_err  output  1  misaligned or illegal funct3, valid with resp_valid.
REQ-013 mem_data_out  output  32  aligned, extended load data to MEM/WB mem_data_in.

Function
REQ-014 FSM states IDLE, WAIT, DONE; encoding free.
REQ-015 IDLE with req_valid=1: accept; go WAIT if LATENCY>1, else DONE; latch addr, we, funct3, wdata.
REQ-016 WAIT: stay exactly LATENCY-1 cycles via down-counter, then go DONE.
REQ-017 DONE: resp_valid=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 req_valid in DONE is ignored (it is the request being completed); no new accept until IDLE.
REQ-019 stall = (state==WAIT) | (state==IDLE & req_valid); stall=0 in DONE and in IDLE without request.
REQ-020 Accept at cycle T -> resp_valid at cycle T+LATENCY; back-to-back requests accepted every LATENCY+1 cycles.
REQ-021 Memory access SHALL occur on the edge entering DONE, using the latched request.
REQ-022 Word index = addr[ADDR_WORD_BITS+1:2]; upper address bits ignored (wrap-around).
REQ-023 Loads: 000 LB and 100 LBU select byte addr[1:0]; 001 LH and 101 LHU select halfword addr[1]; 010 LW full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 Stores: 000 SB writes byte addr[1:0]=wdata[7:0]; 001 SH writes halfword addr[1]=wdata[15:0]; 010 SW writes word; other bytes unchanged.
REQ-025 Misaligned (halfword with addr[0]=1; word with addr[1:0]!=0) or funct3 not listed above: no array write, mem_data_out=0, resp_err=1.
REQ-026 mem_data_out and resp_err registered at the edge entering DONE; held until next response update.
REQ-027 Store response: mem_data_out=0, resp_err per REQ-025.
REQ-028 A load accepted after a store's DONE cycle SHALL return the stored data.

Reset
REQ-029 rst=1 on an edge: state=IDLE, counter=0, resp_valid=0, resp_err=0, mem_data_out=0; stall follows REQ-019 (stall=req_valid).
REQ-030 rst during WAIT discards the pending access: no array write, no response.
REQ-031 Array contents unaffected by rst; power-up contents undefined.

Verification
REQ-032 LATENCY=2, SW addr 0x10 data 0xDEADBEEF at T -> stall=1 at T,T+1; resp_valid=1, stall=0 at T+2; then LW 0x10 -> mem_data_out=0xDEADBEEF, resp_err=0.
REQ-033 Word 0x10=0x80FF7F01: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
REQ-034 SB 0x11 data 0x000000AA over word 0x11223344, then LW 0x10 -> 0x1122AA44.
REQ-035 LW 0x12 or LH 0x11 or funct3=011 -> resp_err=1, mem_data_out=0; prior SW 0x13 leaves array unchanged.
REQ-036 LATENCY=1, req_valid held high through DONE -> exactly one resp_valid per request, pulses at T+1, T+3, T+5.
REQ-037 SW 0x20 data 0x12345678, rst in WAIT -> resp_valid never asserts; later LW 0x20 returns the pre-store value.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the MEM stage of an RV32I pipeline.
// Accepts one load/store at a time. The response appears LATENCY cycles
// after accept, and the pipeline is stalled while the access is in flight.
// Loads are aligned and sign- or zero-extended. Stores merge bytes into the
// word they target. Misaligned or unknown accesses return an error and
// leave the array untouched.
`timescale 1ns/1ps
module data_mem_ctrl #(
  parameter int ADDR_WORD_BITS = 8,
  parameter int LATENCY        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] mem_data_out
);

  localparam int DATA_W = 32;
  localparam int AW     = ADDR_WORD_BITS;
  localparam int DEPTH  = 1 << AW;
  // The WAIT state lasts LATENCY-1 cycles, so the counter is loaded with
  // LATENCY-2 and DONE is entered when it reads zero.
  localparam logic [2:0] CNT_INIT = 3'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [AW+1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              acc_we;
  logic [2:0]        acc_f3;
  logic [AW+1:0]     acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] acc_word;
  logic [DATA_W-1:0] acc_rdata;
  logic [DATA_W-1:0] acc_merged;
  logic              acc_err;
  logic              enter_done;
  logic              mem_wr;
  logic              unused_addr_bits;

  // Returns 1 when funct3 is not a legal load/store or the address is misaligned.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic e;
    e = 1'b1;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Selects a byte, halfword or word from the word and extends it to 32 bits.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] a);
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] sx_b;
    logic signed [DATA_W-1:0] sx_h;
    logic [DATA_W-1:0]        r;
    b    = word[{a, 3'b000} +: 8];
    h    = a[1] ? word[31:16] : word[15:0];
    sx_b = b;
    sx_h = h;
    case (f3)
      3'b000:  r = sx_b;
      3'b001:  r = sx_h;
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Merges store data into the bytes the store targets and keeps the other bytes.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] a);
    logic [DATA_W-1:0] r;
    r = word;
    case (f3)
      3'b000: r[{a, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (a[1]) r[31:16] = wd[15:0];
        else      r[15:0]  = wd[15:0];
      end
      3'b010:  r = wd;
      default: r = word;
    endcase
    return r;
  endfunction

  // Upper address bits wrap around and are intentionally ignored.
  assign unused_addr_bits = ^req_addr[DATA_W-1:AW+2];

  // Picks the access source. With LATENCY=1 the access happens on the accept
  // edge, before the latch holds the request, so the live inputs are used.
  always_comb begin
    acc_we    = we_q;
    acc_f3    = f3_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr[AW+1:0];
      acc_wdata = req_wdata;
    end
  end

  assign acc_err    = access_err(acc_we, acc_f3, acc_addr[1:0]);
  assign acc_word   = mem_q[acc_addr[AW+1:2]];
  assign acc_rdata  = (acc_we || acc_err) ? '0 : load_extract(acc_word, acc_f3, acc_addr[1:0]);
  assign acc_merged = store_merge(acc_word, acc_wdata, acc_f3, acc_addr[1:0]);

  assign enter_done = !rst &&
                      (((state_q == S_IDLE) && req_valid && (LATENCY == 1)) ||
                       ((state_q == S_WAIT) && (cnt_q == 3'd0)));
  assign mem_wr     = enter_done && acc_we && !acc_err;

  assign stall        = (state_q == S_WAIT) || ((state_q == S_IDLE) && req_valid);
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign mem_data_out = rdata_q;

  // Writes the array on the edge entering DONE. The array has no reset.
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[acc_addr[AW+1:2]] <= acc_merged;
  end

  // Handles control: the request FSM, the latency counter, the request latch and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (enter_done) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= acc_err;
        rdata_q      <= acc_rdata;
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            if (LATENCY > 1) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) state_q <= S_DONE;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a LATENCY=2 instance for the main
// function and a LATENCY=1 instance for the back-to-back response pattern.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, resp_err;
  logic [31:0] mem_data_out;

  logic        req_valid1, req_we1;
  logic [2:0]  req_funct31;
  logic [31:0] req_addr1, req_wdata1;
  logic        stall1, resp_valid1, resp_err1;
  logic [31:0] mem_data_out1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WORD_BITS(8), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_err(resp_err),
    .mem_data_out(mem_data_out)
  );

  data_mem_ctrl #(.ADDR_WORD_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_we(req_we1),
    .req_funct3(req_funct31), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .stall(stall1), .resp_valid(resp_valid1), .resp_err(resp_err1),
    .mem_data_out(mem_data_out1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request to the LATENCY=2 instance, starting just after a
  // rising edge with the DUT idle, and returning just after the next idle edge.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e);
    int lat;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (resp_valid !== 1'b1 && lat < 16);
    req_valid = 1'b0;
    chk({tag, "_lat"},  32'(lat), 32'd2);
    chk({tag, "_data"}, mem_data_out, exp_d);
    chk({tag, "_err"},  32'(resp_err), 32'(exp_e));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_funct31 = 3'b000; req_addr1 = '0; req_wdata1 = '0;

    // Reset state; stall follows req_valid while in reset
    @(posedge clk); #1;
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_rv",    32'(resp_valid), 32'd0);
    chk("rst_err",   32'(resp_err), 32'd0);
    chk("rst_data",  mem_data_out, 32'h0);
    chk("rst_rv1",   32'(resp_valid1), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd0);

    // SW 0x10 DEADBEEF, cycle by cycle
    @(posedge clk); #1;
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(negedge clk);
    chk("sw_T_stall",  32'(stall), 32'd1);
    chk("sw_T_rv",     32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_T1_stall", 32'(stall), 32'd1);
    chk("sw_T1_rv",    32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_T2_rv",    32'(resp_valid), 32'd1);
    chk("sw_T2_stall", 32'(stall), 32'd0);
    chk("sw_T2_err",   32'(resp_err), 32'd0);
    chk("sw_T2_data",  mem_data_out, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Load extraction and extension
    txn("sw10b", 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 1'b0);
    txn("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
    txn("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0);
    txn("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 1'b0);

    // Byte store merge
    txn("sw10c", 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0);
    txn("sb11",  1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0);
    txn("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1122AA44, 1'b0);

    // Misaligned and illegal accesses
    txn("lw12",   1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    txn("lh11",   1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
    txn("ld011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    txn("sw13",   1'b1, 3'b010, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("lw10d",  1'b0, 3'b010, 32'h10, 32'h0, 32'h1122AA44, 1'b0);

    // Halfword store, address wrap-around, signed halfword load
    txn("sh12",   1'b1, 3'b001, 32'h12, 32'h0000BEEF, 32'h0, 1'b0);
    txn("lw410",  1'b0, 3'b010, 32'h410, 32'h0, 32'hBEEFAA44, 1'b0);
    txn("lh12b",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0);

    // Reset during WAIT discards the store
    txn("sw20", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rstw_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstw_rv%0d", i), 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    txn("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // LATENCY=1 with req_valid held high: pulses at T+1, T+3, T+5
    req_we1 = 1'b1; req_funct31 = 3'b010; req_addr1 = 32'h40; req_wdata1 = 32'h00000055; req_valid1 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("l1_rv_c%0d", c),    32'(resp_valid1), 32'(c == 1 || c == 3 || c == 5));
      chk($sformatf("l1_stall_c%0d", c), 32'(stall1),      32'(c % 2 == 0));
      if (c < 6) begin
        @(posedge clk); #1;
      end
    end
    req_valid1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_we1 = 1'b0; req_valid1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1_lw_rv",   32'(resp_valid1), 32'd1);
    chk("l1_lw_data", mem_data_out1, 32'h00000055);
    chk("l1_lw_err",  32'(resp_err1), 32'd0);
    req_valid1 = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
